// File: rtl/rf_pkg.sv
// Shared register-file constants: widths, writeback source indices, zero register.
package rf_pkg;
    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NREGS    = 1 << REG_AW;
    localparam int NREQ_DEF = 3;

    localparam int WB_ALU = 0;
    localparam int WB_LSU = 1;
    localparam int WB_MDU = 2;

    localparam logic [REG_AW-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [XLEN-1:0]   data;
    } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: requester valid/ready lanes, issue-side alloc, regfile write port, scoreboard.
interface regfile_wb_arbiter_if #(
    parameter int NREQ = rf_pkg::NREQ_DEF,
    parameter int XLEN = rf_pkg::XLEN,
    parameter int AW   = rf_pkg::REG_AW
);
    logic [NREQ-1:0]      i_req_valid;
    logic [NREQ*AW-1:0]   i_req_addr;
    logic [NREQ*XLEN-1:0] i_req_data;
    logic [NREQ-1:0]      o_req_ready;
    logic                 i_alloc_valid;
    logic [AW-1:0]        i_alloc_addr;
    logic                 o_wen;
    logic [AW-1:0]        o_rd_addr;
    logic [XLEN-1:0]      o_rd;
    logic [(1<<AW)-1:0]   o_pending;

    modport master (
        output i_req_valid, i_req_addr, i_req_data, i_alloc_valid, i_alloc_addr,
        input  o_req_ready, o_wen, o_rd_addr, o_rd, o_pending
    );

    modport slave (
        input  i_req_valid, i_req_addr, i_req_data, i_alloc_valid, i_alloc_addr,
        output o_req_ready, o_wen, o_rd_addr, o_rd, o_pending
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from ptr upward, ptr moves past the winner.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt
);
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   nxt_ptr;
    logic [NREQ-1:0] hi_req;
    logic [NREQ-1:0] src;

    always_comb begin
        hi_req  = '0;
        gnt     = '0;
        nxt_ptr = ptr;
        for (int k = 0; k < NREQ; k++)
            hi_req[k] = req[k] && (PW'(k) >= ptr);
        // requests at or above ptr take precedence; otherwise wrap to the bottom
        src = (|hi_req) ? hi_req : req;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (src[k]) begin
                gnt     = '0;
                gnt[k]  = 1'b1;
                nxt_ptr = (k == NREQ - 1) ? '0 : PW'(k + 1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr <= '0;
        else     ptr <= nxt_ptr;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Regfile writeback arbiter: shares one write port among NREQ sources through a
// registered output stage and tracks outstanding writes in a pending scoreboard.
module regfile_wb_arbiter #(
    parameter int NREQ = rf_pkg::NREQ_DEF,
    parameter int XLEN = rf_pkg::XLEN,
    parameter int AW   = rf_pkg::REG_AW
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int NREGS = 1 << AW;

    logic [NREQ-1:0]  gnt;
    logic             any_gnt;
    logic [AW-1:0]    gnt_addr;
    logic [XLEN-1:0]  gnt_data;
    logic             wr_fire;
    logic             wen_q;
    logic [AW-1:0]    rd_addr_q;
    logic [XLEN-1:0]  rd_q;
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pend_nxt;
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] clr_vec;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (bus.i_req_valid),
        .gnt (gnt)
    );

    assign bus.o_req_ready = gnt;
    assign any_gnt         = |gnt;

    always_comb begin
        gnt_addr = '0;
        gnt_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt[k]) begin
                gnt_addr = bus.i_req_addr[k*AW +: AW];
                gnt_data = bus.i_req_data[k*XLEN +: XLEN];
            end
        end
    end

    // writes to the zero register are consumed but never reach the regfile
    assign wr_fire = any_gnt && (gnt_addr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_q     <= 1'b0;
            rd_addr_q <= '0;
            rd_q      <= '0;
        end else begin
            wen_q <= wr_fire;
            if (wr_fire) begin
                rd_addr_q <= gnt_addr;
                rd_q      <= gnt_data;
            end
        end
    end

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (bus.i_alloc_valid) set_vec[bus.i_alloc_addr] = 1'b1;
        if (wen_q)             clr_vec[rd_addr_q]        = 1'b1;
        // set after clear: a new producer allocated on the commit edge keeps the bit
        pend_nxt    = (pending & ~clr_vec) | set_vec;
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= pend_nxt;
    end

    assign bus.o_wen     = wen_q;
    assign bus.o_rd_addr = rd_addr_q;
    assign bus.o_rd      = rd_q;
    assign bus.o_pending = pending;

    // issue must stall on a pending destination unless it retires on this very edge
    a_no_double_alloc : assert property (@(posedge clk) disable iff (rst)
        bus.i_alloc_valid |-> !(pending[bus.i_alloc_addr] && !clr_vec[bus.i_alloc_addr]));
endmodule
